// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU command sequencer.
//   - opcode constants for the 8-bit, 4-bit-opcode ALU
//   - sequencer FSM state encoding
//   - op_has_carry(): which opcodes report a meaningful carry
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD     = 4'h0;
    localparam logic [3:0] OP_SUB     = 4'h1;
    localparam logic [3:0] OP_AND     = 4'h2;
    localparam logic [3:0] OP_OR      = 4'h3;
    localparam logic [3:0] OP_XOR     = 4'h4;
    localparam logic [3:0] OP_NAND    = 4'h5;
    localparam logic [3:0] OP_NOR     = 4'h6;
    localparam logic [3:0] OP_XNOR    = 4'h7;
    localparam logic [3:0] OP_ADD_INC = 4'h8;
    localparam logic [3:0] OP_SUB_DEC = 4'h9;
    localparam logic [3:0] OP_NOT_A   = 4'hA;
    localparam logic [3:0] OP_NOT_B   = 4'hB;
    localparam logic [3:0] OP_PASS_A  = 4'hC;
    localparam logic [3:0] OP_PASS_B  = 4'hD;
    localparam logic [3:0] OP_ZERO    = 4'hE;
    localparam logic [3:0] OP_NOT_NOT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } seq_state_t;

    // Only the add/sub family (0x0, 0x1, 0x8, 0x9) produces a real carry;
    // for the logical opcodes the ALU carry pin is meaningless.
    function automatic logic op_has_carry(input logic [3:0] op);
        return (op[2:1] == 2'b00);
    endfunction

endpackage

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: command sequencer in front of a combinational 8-bit ALU.
// Accepts a command (operands + opcode) on a valid/ready channel, holds it
// on registered ALU inputs for WAIT_CYC cycles, captures result and masked
// carry, and returns them on a valid/ready response channel.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_a, cmd_b, cmd_op          operands and opcode
//   cmd_chain                     use accumulator as operand A (ALU_CHAIN_EN)
//   alu_bin1, alu_bin2, alu_opcode registered ALU inputs
//   alu_out, alu_carry            ALU result and carry
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_carry, rsp_op   captured response
//   done_cnt                      completed responses, wraps at 16 bits
//
// Build option: define ALU_CHAIN_EN to build the result accumulator and
// honour cmd_chain. Without it cmd_chain is ignored.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | ready for a command, ALU inputs keep last value
// ST_DRIVE | ALU inputs held, wait counter running
// ST_RESP  | response presented, waiting for rsp_ready
module alu_cmd_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [3:0]  cmd_op,
    input  logic        cmd_chain,
    output logic [7:0]  alu_bin1,
    output logic [7:0]  alu_bin2,
    output logic [3:0]  alu_opcode,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_carry,
    output logic [3:0]  rsp_op,
    output logic [15:0] done_cnt
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYC - 1);

    seq_state_t state;
    logic [3:0] wait_cnt;
    logic [7:0] bin1_next;
    logic       rsp_fire;

    // Gated by rst so nothing is accepted while reset is asserted.
    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign rsp_fire  = rsp_valid && rsp_ready;

`ifdef ALU_CHAIN_EN
    logic [7:0] acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= 8'h00;
        end else if (state == ST_RESP && rsp_fire) begin
            acc <= rsp_data;
        end
    end

    assign bin1_next = cmd_chain ? acc : cmd_a;
`else
    logic unused_chain;

    assign unused_chain = cmd_chain;
    assign bin1_next    = cmd_a;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            alu_bin1   <= 8'h00;
            alu_bin2   <= 8'h00;
            alu_opcode <= 4'h0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 8'h00;
            rsp_carry  <= 1'b0;
            rsp_op     <= 4'h0;
            done_cnt   <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        alu_bin1   <= bin1_next;
                        alu_bin2   <= cmd_b;
                        alu_opcode <= cmd_op;
                        wait_cnt   <= WAIT_LOAD;
                        state      <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (wait_cnt == 4'd0) begin
                        rsp_data  <= alu_out;
                        rsp_op    <= alu_opcode;
                        rsp_carry <= alu_carry & op_has_carry(alu_opcode);
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_fire) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + 16'd1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_seq.sv
module tb_alu_cmd_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: add/sub produce a true carry/borrow; logical ops drive
    // the carry pin high so the sequencer's masking is visible.
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
        case (op)
            4'h0:    return {1'b0, a} + {1'b0, b};
            4'h1:    return {1'b0, a} - {1'b0, b};
            4'h2:    return {1'b1, a & b};
            4'h3:    return {1'b1, a | b};
            default: return {1'b1, a ^ b};
        endcase
    endfunction

    // ---------------- DUT with WAIT_CYC = 1 ----------------
    logic        rst, cmd_valid, cmd_ready, cmd_chain;
    logic [7:0]  cmd_a, cmd_b, alu_bin1, alu_bin2, alu_out, rsp_data;
    logic [3:0]  cmd_op, alu_opcode, rsp_op;
    logic        alu_carry, rsp_valid, rsp_ready, rsp_carry;
    logic [15:0] done_cnt;

    assign {alu_carry, alu_out} = alu_f(alu_bin1, alu_bin2, alu_opcode);

    alu_cmd_seq #(.WAIT_CYC(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
        .alu_bin1(alu_bin1), .alu_bin2(alu_bin2), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_op(rsp_op),
        .done_cnt(done_cnt)
    );

    // ---------------- DUT with WAIT_CYC = 4 ----------------
    logic        rst_4, cmd_valid_4, cmd_ready_4, cmd_chain_4;
    logic [7:0]  cmd_a_4, cmd_b_4, alu_bin1_4, alu_bin2_4, alu_out_4, rsp_data_4;
    logic [3:0]  cmd_op_4, alu_opcode_4, rsp_op_4;
    logic        alu_carry_4, rsp_valid_4, rsp_ready_4, rsp_carry_4;
    logic [15:0] done_cnt_4;

    assign {alu_carry_4, alu_out_4} = alu_f(alu_bin1_4, alu_bin2_4, alu_opcode_4);

    alu_cmd_seq #(.WAIT_CYC(4)) dut_4 (
        .clk(clk), .rst(rst_4),
        .cmd_valid(cmd_valid_4), .cmd_ready(cmd_ready_4),
        .cmd_a(cmd_a_4), .cmd_b(cmd_b_4), .cmd_op(cmd_op_4), .cmd_chain(cmd_chain_4),
        .alu_bin1(alu_bin1_4), .alu_bin2(alu_bin2_4), .alu_opcode(alu_opcode_4),
        .alu_out(alu_out_4), .alu_carry(alu_carry_4),
        .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready_4),
        .rsp_data(rsp_data_4), .rsp_carry(rsp_carry_4), .rsp_op(rsp_op_4),
        .done_cnt(done_cnt_4)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_done = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command on the WAIT_CYC=1 DUT and complete its response.
    task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op, input logic chain,
                           input logic [7:0] exp_bin1, input logic [7:0] exp_d,
                           input logic exp_c);
        int lat;
        chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = chain;
        rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0; cmd_chain = 1'b0;
        chk({tag, "_bin1"}, {24'd0, alu_bin1}, {24'd0, exp_bin1});
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, 32'd1);
        chk({tag, "_data"}, {24'd0, rsp_data}, {24'd0, exp_d});
        chk({tag, "_carry"}, {31'd0, rsp_carry}, {31'd0, exp_c});
        chk({tag, "_op"}, {28'd0, rsp_op}, {28'd0, op});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_done++;
        chk({tag, "_done"}, {16'd0, done_cnt}, exp_done);
        chk({tag, "_vclr"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [7:0] exp_a;
        logic [8:0] exp_r;

        rst = 1'b1; cmd_valid = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_op = 4'h0;
        cmd_chain = 1'b0; rsp_ready = 1'b0;
        rst_4 = 1'b1; cmd_valid_4 = 1'b0; cmd_a_4 = 8'h00; cmd_b_4 = 8'h00;
        cmd_op_4 = 4'h0; cmd_chain_4 = 1'b0; rsp_ready_4 = 1'b0;
        tick(); tick();

        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_outs", {rsp_valid, rsp_carry, rsp_op, rsp_data, alu_bin1, alu_bin2, alu_opcode},
            32'd0);
        chk("rst_done", {16'd0, done_cnt}, 32'd0);
        rst = 1'b0; rst_4 = 1'b0;
        #1;
        chk("rel_ready", {31'd0, cmd_ready}, 32'd1);
        tick();

        // add / sub / and / logical with masked carry / overflow
        run_cmd("add", 8'h0D, 8'hF1, 4'h0, 1'b0, 8'h0D, 8'hFE, 1'b0);
        run_cmd("sub", 8'h0D, 8'hF1, 4'h1, 1'b0, 8'h0D, 8'h1C, 1'b1);
        run_cmd("and", 8'h0D, 8'hF1, 4'h2, 1'b0, 8'h0D, 8'h01, 1'b0);
        run_cmd("xora", 8'h3C, 8'h0F, 4'hA, 1'b0, 8'h3C, 8'h33, 1'b0);
        run_cmd("xor9", 8'h3C, 8'h0F, 4'h9, 1'b0, 8'h3C, 8'h33, 1'b1);
        run_cmd("ovf", 8'hFF, 8'h01, 4'h0, 1'b0, 8'hFF, 8'h00, 1'b1);

        // ALU inputs keep their last value in IDLE
        tick();
        chk("idle_hold", {24'd0, alu_bin1}, 32'hFF);

        // chaining: accumulator holds 0xFE after the add
        run_cmd("base", 8'h0D, 8'hF1, 4'h0, 1'b0, 8'h0D, 8'hFE, 1'b0);
`ifdef ALU_CHAIN_EN
        exp_a = 8'hFE;
`else
        exp_a = 8'h55;
`endif
        exp_r = {1'b0, exp_a} + 9'h003;
        run_cmd("chain", 8'h55, 8'h03, 4'h0, 1'b1, exp_a, exp_r[7:0], exp_r[8]);

        // backpressure with a pending command
        cmd_valid = 1'b1; cmd_a = 8'h21; cmd_b = 8'h12; cmd_op = 4'h0;
        tick();
        cmd_a = 8'h40; cmd_b = 8'h02; cmd_op = 4'h3;
        tick();
        chk("bp_valid0", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", {rsp_valid, cmd_ready, rsp_carry, rsp_op, rsp_data}, {18'd0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h33});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_done++;
        chk("bp_done", {16'd0, done_cnt}, exp_done);
        chk("bp_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("bp_accept", {20'd0, alu_opcode, alu_bin1}, 32'h340);
        chk("bp_busy", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("bp_rsp2", {24'd0, rsp_data}, 32'h42);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_done++;
        chk("bp_done2", {16'd0, done_cnt}, exp_done);

        // reset during DRIVE on the WAIT_CYC=4 instance
        cmd_valid_4 = 1'b1; cmd_a_4 = 8'h12; cmd_b_4 = 8'h34; cmd_op_4 = 4'h0;
        tick();
        cmd_valid_4 = 1'b0;
        chk("r4_bin1", {24'd0, alu_bin1_4}, 32'h12);
        tick(); tick();
        rst_4 = 1'b1;
        #1;
        chk("r4_outs", {rsp_valid_4, rsp_carry_4, rsp_op_4, rsp_data_4, alu_bin1_4, alu_bin2_4, alu_opcode_4},
            32'd0);
        chk("r4_done", {16'd0, done_cnt_4}, 32'd0);
        chk("r4_rdy_rst", {31'd0, cmd_ready_4}, 32'd0);
        tick();
        rst_4 = 1'b0;
        #1;
        chk("r4_rdy_rel", {31'd0, cmd_ready_4}, 32'd1);
        rsp_ready_4 = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("r4_norsp", {15'd0, rsp_valid_4, done_cnt_4}, 32'd0);
        rsp_ready_4 = 1'b0;

        // full command on the WAIT_CYC=4 instance
        cmd_valid_4 = 1'b1; cmd_a_4 = 8'h12; cmd_b_4 = 8'h34; cmd_op_4 = 4'h0;
        tick();
        cmd_valid_4 = 1'b0;
        lat = 0;
        while (!rsp_valid_4 && lat < 20) begin
            tick();
            lat++;
        end
        chk("w4_lat", lat, 32'd4);
        chk("w4_data", {24'd0, rsp_data_4}, 32'h46);
        rsp_ready_4 = 1'b1;
        tick();
        rsp_ready_4 = 1'b0;
        chk("w4_done", {16'd0, done_cnt_4}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Command sequencer that drives the 8-bit, 4-bit-opcode combinational ALU. It accepts operand/opcode commands on a valid/ready channel and presents them to the ALU as stable registered inputs. After a programmable settle time it captures the ALU result and carry. It returns them on a valid/ready response channel. It sits between the control path and the ALU instance.

## Interface
Parameters:
- `WAIT_CYC`, default 1: number of cycles ALU inputs are held before sampling. Legal range is 1..15.

Ports:
- `clk`  in  1: clock. All logic is on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: sequencer can accept a command.
- `cmd_a`  in  8: operand A.
- `cmd_b`  in  8: operand B.
- `cmd_op`  in  4: ALU opcode, 0x0..0xF.
- `cmd_chain`  in  1: use the accumulator as A. Only meaningful under `ALU_CHAIN_EN`.
- `alu_bin1`  out  8: ALU operand A.
- `alu_bin2`  out  8: ALU operand B.
- `alu_opcode`  out  4: ALU opcode.
- `alu_out`  in  8: ALU result.
- `alu_carry`  in  1: ALU carry.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_data`  out  8: captured result.
- `rsp_carry`  out  1: captured carry, masked.
- `rsp_op`  out  4: opcode of this response.
- `done_cnt`  out  16: number of completed responses. Wraps 0xFFFF to 0x0000.

## Operation
- FSM states are IDLE, DRIVE and RESP. Reset state is IDLE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid && cmd_ready`, latch the operands and opcode into the ALU input registers.
  - Load the wait counter with `WAIT_CYC-1` and go to DRIVE.
- DRIVE:
  - `cmd_ready`=0. The ALU inputs are held constant.
  - When the counter reaches 0, capture `alu_out` into `rsp_data`, `alu_opcode` into `rsp_op`, and the masked carry into `rsp_carry`.
  - Set `rsp_valid`=1 and go to RESP.
  - Otherwise decrement the counter.
- RESP:
  - `rsp_valid`=1. All `rsp_*` outputs are stable until the handshake.
  - On `rsp_valid && rsp_ready`: clear `rsp_valid`, increment `done_cnt`, go to IDLE.
- Carry masking:
  - `rsp_carry = alu_carry & (op[2:1]==2'b00)`.
  - Carry is reported only for opcodes 0x0, 0x1, 0x8 and 0x9 (add/sub variants). It is forced to 0 for logical opcodes.
- ALU inputs keep their last driven values in IDLE. They do not return to 0 between commands.
- Only one command is in flight. `cmd_valid` asserted outside IDLE is ignored, not lost, because `cmd_ready`=0.

## Timing
- Reset values:
  - `cmd_ready`=0 while `rst` is high; it is 1 in the first cycle after release.
  - `rsp_valid`=0, and `rsp_data`, `rsp_carry` and `rsp_op` are 0.
  - `alu_bin1`, `alu_bin2` and `alu_opcode` are 0.
  - `done_cnt`=0 and the accumulator is 0.
- Per-command timing (T is the accept edge):
  - Accept at edge T: the ALU inputs update at T.
  - Sample at edge T+`WAIT_CYC`: `rsp_valid` is high from then on.
  - With `rsp_ready` held at 1, the handshake occurs at T+`WAIT_CYC`+1.
  - `cmd_ready` returns at that point, so the minimum command period is `WAIT_CYC`+2 cycles.
- Backpressure: `rsp_ready`=0 holds RESP indefinitely with no change to any output.
- Reset mid-operation (DRIVE or RESP):
  - The in-flight command is discarded.
  - No response is produced and `done_cnt` does not increment.
- `done_cnt` wrap: 0xFFFF plus one completion gives 0x0000. No flag is raised.

## Configuration
- `ALU_CHAIN_EN` defined:
  - An 8-bit accumulator register is loaded with `rsp_data` on each response handshake. Reset value is 0.
  - A command with `cmd_chain`=1 drives the accumulator onto `alu_bin1` instead of `cmd_a`.
- `ALU_CHAIN_EN` undefined:
  - No accumulator is built.
  - `cmd_chain` is ignored and `alu_bin1` always comes from `cmd_a`.

## Structure
- Package `alu_seq_pkg` holds:
  - the opcode constants `OP_ADD`(0x0) through `OP_NOT_NOT`(0xF);
  - the FSM state enum;
  - a function `op_has_carry(op)` implementing the carry mask.
- No sub-module. The ALU is instantiated by the parent, not inside this block.

## Test plan
- ADD: A=0x0D, B=0xF1, op=0x0, `WAIT_CYC`=1 gives `rsp_data`=0xFE, `rsp_carry`=0. `rsp_valid` rises exactly 1 cycle after the accept edge.
- SUB: A=0x0D, B=0xF1, op=0x1 gives `rsp_data`=0x1C, `rsp_carry`=1. AND on the same operands (op=0x2) gives `rsp_data`=0x01, `rsp_carry`=0, with the carry masked.
- Overflow: A=0xFF, B=0x01, op=0x0 gives `rsp_data`=0x00, `rsp_carry`=1, and `done_cnt` increments by 1.
- Backpressure: hold `rsp_ready`=0 for 5 cycles during RESP. `rsp_valid` and data are held, `cmd_ready`=0 throughout, and a pending `cmd_valid` is accepted the cycle after the handshake.
- Reset during DRIVE with `WAIT_CYC`=4, asserting `rst` 2 cycles after accept: no `rsp_valid`, `done_cnt` unchanged, all outputs 0, `cmd_ready`=1 after release.
- `ALU_CHAIN_EN`:
  - First, ADD 0x0D+0xF1 gives 0xFE.
  - Then `cmd_chain`=1, B=0x03, op=0x0 drives `alu_bin1`=0xFE and gives `rsp_data`=0x01, `rsp_carry`=1.
  - With the macro undefined, the same sequence uses `cmd_a`.
